// File: rtl/lc3b_types.sv
// Shared LC-3b types: data word, burst beat index and the pmem burst bridge states.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_beat;

  typedef enum logic [1:0] {
    IDLE,
    READ_BEAT,
    WRITE_BEAT,
    RESPOND
  } lc3b_burst_state;

  localparam int BEATS_PER_LINE = 8;

endpackage

// File: rtl/line_word_slicer.sv
// Combinational pick of one word out of a cache line, word k at bits [k*W +: W].
module line_word_slicer #(
  parameter int WORD_WIDTH = 16,
  parameter int BEATS      = 8
) (
  input  logic [WORD_WIDTH*BEATS-1:0] line,
  input  logic [$clog2(BEATS)-1:0]    beat,
  output logic [WORD_WIDTH-1:0]       word
);

  logic [WORD_WIDTH-1:0] words [BEATS];

  for (genvar gi = 0; gi < BEATS; gi++) begin : g_split
    assign words[gi] = line[gi*WORD_WIDTH +: WORD_WIDTH];
  end

  assign word = words[beat];

endmodule

// File: rtl/pmem_burst_bridge.sv
// Responder for the L2 line port: turns one 128-bit line read/write into an
// 8-beat burst of 16-bit word transactions and pulses pmem_resp when done.
module pmem_burst_bridge
  import lc3b_types::*;
#(
  parameter int WORD_WIDTH = 16,
  parameter int BEATS      = BEATS_PER_LINE,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        pmem_read,
  input  logic                        pmem_write,
  input  logic [ADDR_WIDTH-1:0]       pmem_addr,
  input  logic [WORD_WIDTH*BEATS-1:0] pmem_wdata,
  output logic [WORD_WIDTH*BEATS-1:0] pmem_rdata,
  output logic                        pmem_resp,
  output logic                        word_read,
  output logic                        word_write,
  output logic [ADDR_WIDTH-1:0]       word_addr,
  output logic [WORD_WIDTH-1:0]       word_wdata,
  input  logic [WORD_WIDTH-1:0]       word_rdata,
  input  logic                        word_resp
);

  localparam int LINE_WIDTH  = WORD_WIDTH * BEATS;
  localparam int BEAT_W      = $clog2(BEATS);
  localparam int BYTE_OFF_W  = $clog2(WORD_WIDTH / 8);
  localparam int LINE_OFF_W  = BYTE_OFF_W + BEAT_W;
  localparam int LINE_ADDR_W = ADDR_WIDTH - LINE_OFF_W;

  lc3b_burst_state          state_reg;
  lc3b_beat                 beat_reg;
  lc3b_beat                 beat_next;
  logic [LINE_ADDR_W-1:0]   line_addr_reg;
  logic [LINE_WIDTH-1:0]    line_buf_reg;
  logic [WORD_WIDTH-1:0]    next_wdata;
  logic [WORD_WIDTH-1:0]    rdata_slot_reg [BEATS];
  logic                     last_beat;
  logic                     beat_done;
  logic                     unused_addr_bits;

  assign unused_addr_bits = ^pmem_addr[LINE_OFF_W-1:0];

  assign beat_next = beat_reg + lc3b_beat'(1);
  assign last_beat = (beat_reg == lc3b_beat'(BEATS - 1));
  assign beat_done = word_resp && ((state_reg == READ_BEAT) || (state_reg == WRITE_BEAT));

  // Outputs are registered, so the word for the upcoming beat is selected one cycle early.
  line_word_slicer #(
    .WORD_WIDTH (WORD_WIDTH),
    .BEATS      (BEATS)
  ) u_slicer (
    .line (line_buf_reg),
    .beat (beat_next),
    .word (next_wdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      beat_reg      <= '0;
      line_addr_reg <= '0;
      line_buf_reg  <= '0;
      pmem_resp     <= 1'b0;
      word_read     <= 1'b0;
      word_write    <= 1'b0;
      word_addr     <= '0;
      word_wdata    <= '0;
    end else begin
      pmem_resp <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pmem_write || pmem_read) begin
            line_addr_reg <= pmem_addr[ADDR_WIDTH-1:LINE_OFF_W];
            line_buf_reg  <= pmem_wdata;
            beat_reg      <= '0;
            word_addr     <= {pmem_addr[ADDR_WIDTH-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
            word_wdata    <= pmem_wdata[WORD_WIDTH-1:0];
            if (pmem_write) begin
              state_reg  <= WRITE_BEAT;
              word_write <= 1'b1;
            end else begin
              state_reg <= READ_BEAT;
              word_read <= 1'b1;
            end
          end
        end
        READ_BEAT, WRITE_BEAT: begin
          if (word_resp) begin
            beat_reg <= beat_next;
            if (last_beat) begin
              state_reg  <= RESPOND;
              pmem_resp  <= 1'b1;
              word_read  <= 1'b0;
              word_write <= 1'b0;
            end else begin
              word_addr  <= {line_addr_reg, beat_next, {BYTE_OFF_W{1'b0}}};
              word_wdata <= next_wdata;
            end
          end
        end
        RESPOND: state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Each read slot captures only on its own beat, so earlier slots keep their data.
  for (genvar gi = 0; gi < BEATS; gi++) begin : g_rdata
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata_slot_reg[gi] <= '0;
      end else if (beat_done && (state_reg == READ_BEAT) && (beat_reg == lc3b_beat'(gi))) begin
        rdata_slot_reg[gi] <= word_rdata;
      end
    end
    assign pmem_rdata[gi*WORD_WIDTH +: WORD_WIDTH] = rdata_slot_reg[gi];
  end

endmodule

// File: tb/tb_pmem_burst_bridge.sv
// Directed bench for pmem_burst_bridge: line reads/writes at fixed and slow
// downstream latency, write priority, mid-burst reset and back-to-back requests.
module tb_pmem_burst_bridge;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         pmem_read = 1'b0;
  logic         pmem_write = 1'b0;
  logic [15:0]  pmem_addr = '0;
  logic [127:0] pmem_wdata = '0;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
  logic         word_read;
  logic         word_write;
  logic [15:0]  word_addr;
  logic [15:0]  word_wdata;
  logic [15:0]  word_rdata = '0;
  logic         word_resp = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int resp_pulses = 0;
  int resp_consec = 0;
  logic resp_prev = 1'b0;

  always #5 clk = ~clk;

  pmem_burst_bridge dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pmem_read  (pmem_read),
    .pmem_write (pmem_write),
    .pmem_addr  (pmem_addr),
    .pmem_wdata (pmem_wdata),
    .pmem_rdata (pmem_rdata),
    .pmem_resp  (pmem_resp),
    .word_read  (word_read),
    .word_write (word_write),
    .word_addr  (word_addr),
    .word_wdata (word_wdata),
    .word_rdata (word_rdata),
    .word_resp  (word_resp)
  );

  always @(negedge clk) begin
    if (pmem_resp) resp_pulses++;
    if (pmem_resp && resp_prev) resp_consec++;
    resp_prev <= pmem_resp;
  end

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // One L2 request, driven at negedges. Beat k waits lat cycles, word_resp on the last.
  // abort_at < 8 returns mid-burst; hold keeps the request high into the next IDLE cycle.
  task automatic burst(input logic rd, input logic wr, input logic [15:0] addr,
                       input logic [127:0] wdata, input int lat, input logic [15:0] rbase,
                       input logic [15:0] exp_addr0, input logic [127:0] exp_line,
                       input bit hold, input bit chg_mid, input int abort_at);
    logic [15:0] exp_wa;
    @(negedge clk);
    check_val("idle_resp", pmem_resp, 1'b0);
    check_val("idle_strobes", {word_read, word_write}, 2'b00);
    pmem_read = rd; pmem_write = wr; pmem_addr = addr; pmem_wdata = wdata;
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      if (k == abort_at) return;
      exp_wa = exp_addr0 + 16'(2 * k);
      for (int j = 0; j < lat; j++) begin
        if (chg_mid && k == 3 && j == 0) begin
          pmem_addr = 16'hFFF0;
          pmem_wdata = ~wdata;
        end
        check_val("word_read", word_read, rd && !wr);
        check_val("word_write", word_write, wr);
        check_val("word_addr", word_addr, exp_wa);
        if (wr) check_val("word_wdata", word_wdata, wdata[16*k +: 16]);
        check_val("resp_early", pmem_resp, 1'b0);
        if (j == lat - 1) begin
          word_resp = 1'b1;
          word_rdata = rbase + 16'(k);
        end
        @(negedge clk);
        word_resp = 1'b0;
        word_rdata = 16'hDEAD;
      end
    end
    check_val("resp_pulse", pmem_resp, 1'b1);
    check_val("resp_strobes", {word_read, word_write}, 2'b00);
    if (rd && !wr) check_val("rdata_line", pmem_rdata, exp_line);
    $display("burst rd=%0b wr=%0b addr=%h L=%0d resp at cycle %0d", rd, wr, addr, lat, 1 + 8 * lat);
    if (!hold) begin
      pmem_read = 1'b0;
      pmem_write = 1'b0;
    end
  endtask

  initial begin
    @(negedge clk);
    check_val("rst_state", {pmem_resp, word_read, word_write}, 3'b000);
    check_val("rst_addr_wdata", {word_addr, word_wdata}, 32'h0);
    check_val("rst_rdata", pmem_rdata, 128'h0);
    rst_n = 1'b1;

    // Read, L=1
    burst(1'b1, 1'b0, 16'h1234, 128'h0, 1, 16'hA000, 16'h1230,
          128'hA007_A006_A005_A004_A003_A002_A001_A000, 1'b0, 1'b0, 8);

    // Write
    burst(1'b0, 1'b1, 16'h4000, 128'h7777_6666_5555_4444_3333_2222_1111_0000, 1, 16'h0,
          16'h4000, 128'h0, 1'b0, 1'b0, 8);
    check_val("rdata_hold_after_wr", pmem_rdata, 128'hA007_A006_A005_A004_A003_A002_A001_A000);

    // Read+write together: write wins; pmem_addr/wdata changed mid-burst
    burst(1'b1, 1'b1, 16'h8A5C, 128'h0F0F_1E1E_2D2D_3C3C_4B4B_5A5A_6969_7878, 1, 16'h0,
          16'h8A50, 128'h0, 1'b0, 1'b1, 8);

    // Slow downstream, 3 cycles per beat
    burst(1'b1, 1'b0, 16'hBEE0, 128'h0, 3, 16'hC000, 16'hBEE0,
          128'hC007_C006_C005_C004_C003_C002_C001_C000, 1'b0, 1'b0, 8);

    // Reset during beat 4 of a read
    burst(1'b1, 1'b0, 16'h6000, 128'h0, 1, 16'h9900, 16'h6000, 128'h0, 1'b1, 1'b0, 4);
    check_val("pre_rst_addr", word_addr, 16'h6008);
    #2 rst_n = 1'b0;
    #1;
    check_val("async_rst_strobes", {pmem_resp, word_read, word_write}, 3'b000);
    check_val("async_rst_addr", word_addr, 16'h0);
    check_val("async_rst_rdata", pmem_rdata, 128'h0);
    pmem_read = 1'b0;
    $display("reset applied mid-burst at beat 4");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 1) rst_n = 1'b1;
      check_val("rst_no_resp", pmem_resp, 1'b0);
    end

    // Fresh read after reset
    burst(1'b1, 1'b0, 16'h6000, 128'h0, 1, 16'h5A00, 16'h6000,
          128'h5A07_5A06_5A05_5A04_5A03_5A02_5A01_5A00, 1'b0, 1'b0, 8);

    // Back-to-back: request still high in the IDLE cycle after pmem_resp
    burst(1'b1, 1'b0, 16'h2220, 128'h0, 1, 16'h3300, 16'h2220,
          128'h3307_3306_3305_3304_3303_3302_3301_3300, 1'b1, 1'b0, 8);
    burst(1'b1, 1'b0, 16'h2220, 128'h0, 1, 16'h4400, 16'h2220,
          128'h4407_4406_4405_4404_4403_4402_4401_4400, 1'b0, 1'b0, 8);

    @(negedge clk);
    check_val("final_idle_resp", pmem_resp, 1'b0);
    repeat (2) @(negedge clk);
    check_val("resp_pulse_count", resp_pulses, 7);
    check_val("resp_never_2cyc", resp_consec, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, want finish within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
